regen_engine_multi: RTL



---
 rtl/regen_engine_multi.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/regen_engine_multi.sv
// regen_engine_multi: reads multi-channel capture samples from SDRAM starting at a
// programmable offset inside a circular capture region, stretches each channel by
// S pixels per sample, packs the pixels into 7-bit display bytes and writes the
// per-channel display rows back to SDRAM.
// Optional feature macro: REGEN_PALETTE_EN (per-channel bit-7 colour-group select).
module regen_engine_multi #(
    parameter int                NUM_CH       = 8,
    parameter int                BYTES_PER_CH = 38,
    parameter int                CAP_DEPTH    = 512,
    parameter int                ADDR_W       = 13,
    parameter logic [ADDR_W-1:0] CAP_BASE     = 13'h000,
    parameter logic [ADDR_W-1:0] DISP_BASE    = 13'h200
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [3:0]                   stretch,
    input  logic [$clog2(CAP_DEPTH)-1:0] start_offset,
`ifdef REGEN_PALETTE_EN
    input  logic [NUM_CH-1:0]            palette,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         rd_req,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_ready,
    input  logic [7:0]                   rd_data,
    input  logic                         rd_valid,
    output logic                         wr_req,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [7:0]                   wr_data,
    input  logic                         wr_ready
);

    localparam int OFF_W = $clog2(CAP_DEPTH);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BA_W  = (BYTES_PER_CH > 1) ? $clog2(BYTES_PER_CH) : 1;
    localparam int BI_W  = $clog2(BYTES_PER_CH + 1);
    localparam int BC_W  = 10;
    localparam int TOTAL = 7 * BYTES_PER_CH;

    typedef enum logic [2:0] {
        IDLE, READ, READ_WAIT, PACK, FLUSH, WRITE, DONE
    } state_t;

    state_t state_q, state_d;

    logic [3:0]       s_q;          // effective stretch, 1..15
    logic [OFF_W-1:0] ridx;         // capture index of the next sample to read
    logic [BC_W-1:0]  bit_count;    // pixels committed per channel so far
    logic [BI_W-1:0]  byte_idx;     // next display byte to store
    logic [2:0]       bpos;         // pixel position inside the current byte
    logic [3:0]       rep;          // copies of the current sample emitted
    logic [7:0]       sample_q;
    logic [6:0]       sh [NUM_CH];  // per-channel partial byte
    logic [CH_W-1:0]  wc;           // write channel
    logic [BA_W-1:0]  wb;           // write byte within channel row
    logic             wr_gap;       // one idle cycle after each accepted write
    logic             flag;

    // NOTE: the display buffer has no reset; every byte is rewritten by PACK or
    // FLUSH before WRITE reads it, so resetting it would only add reset fan-out.
    logic [6:0] disp_mem [NUM_CH][BYTES_PER_CH];

    logic fits, last_pix, last_wr;

    assign fits     = (bit_count + BC_W'(s_q)) <= BC_W'(TOTAL);
    assign last_pix = (rep == s_q - 4'd1);
    assign last_wr  = (wc == CH_W'(NUM_CH - 1)) && (wb == BA_W'(BYTES_PER_CH - 1));

`ifdef REGEN_PALETTE_EN
    logic [NUM_CH-1:0] pal_q;
    assign flag = pal_q[wc];
`else
    assign flag = 1'b0;
`endif

    // State register.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and output decode.
    // NOTE: every output and state_d gets a default first so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = READ;
            end
            READ: begin
                busy    = 1'b1;
                rd_req  = fits;
                rd_addr = CAP_BASE + ADDR_W'(ridx);
                if (!fits)         state_d = FLUSH;
                else if (rd_ready) state_d = READ_WAIT;
            end
            READ_WAIT: begin
                busy = 1'b1;
                if (rd_valid) state_d = PACK;
            end
            PACK: begin
                busy = 1'b1;
                if (last_pix) state_d = fits ? READ : FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (byte_idx == BI_W'(BYTES_PER_CH)) state_d = WRITE;
            end
            WRITE: begin
                busy    = 1'b1;
                wr_req  = !wr_gap;
                wr_addr = DISP_BASE + ADDR_W'(wc * BYTES_PER_CH) + ADDR_W'(wb);
                wr_data = {flag, disp_mem[wc][wb]};
                if (!wr_gap && wr_ready && last_wr) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Datapath counters, sample capture and per-channel shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= 4'd1;
            ridx      <= '0;
            bit_count <= '0;
            byte_idx  <= '0;
            bpos      <= '0;
            rep       <= '0;
            sample_q  <= '0;
            wc        <= '0;
            wb        <= '0;
            wr_gap    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) sh[c] <= '0;
`ifdef REGEN_PALETTE_EN
            pal_q     <= '0;
`endif
        end else begin
            wr_gap <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        s_q       <= (stretch == 4'd0) ? 4'd1 : stretch;
                        ridx      <= start_offset;
                        bit_count <= '0;
                        byte_idx  <= '0;
                        bpos      <= '0;
                        rep       <= '0;
                        wc        <= '0;
                        wb        <= '0;
                        for (int c = 0; c < NUM_CH; c++) sh[c] <= '0;
`ifdef REGEN_PALETTE_EN
                        pal_q     <= palette;
`endif
                    end
                end
                READ_WAIT: begin
                    if (rd_valid) begin
                        sample_q  <= rd_data;
                        ridx      <= ridx + 1'b1;
                        bit_count <= bit_count + BC_W'(s_q);
                        rep       <= '0;
                    end
                end
                PACK: begin
                    rep <= rep + 4'd1;
                    for (int c = 0; c < NUM_CH; c++) sh[c][bpos] <= sample_q[c];
                    if (bpos == 3'd6) begin
                        bpos     <= '0;
                        byte_idx <= byte_idx + 1'b1;
                        for (int c = 0; c < NUM_CH; c++) sh[c] <= '0;
                    end else begin
                        bpos <= bpos + 3'd1;
                    end
                end
                FLUSH: begin
                    if (byte_idx != BI_W'(BYTES_PER_CH)) begin
                        bpos     <= '0;
                        byte_idx <= byte_idx + 1'b1;
                        for (int c = 0; c < NUM_CH; c++) sh[c] <= '0;
                    end
                end
                WRITE: begin
                    if (!wr_gap && wr_ready) begin
                        wr_gap <= 1'b1;
                        if (wb == BA_W'(BYTES_PER_CH - 1)) begin
                            wb <= '0;
                            wc <= wc + 1'b1;
                        end else begin
                            wb <= wb + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Display buffer: a completed byte in PACK, or the zero-padded partial /
    // all-zero trailing bytes in FLUSH, stored for every channel at once.
    always_ff @(posedge clk) begin
        if (state_q == PACK && bpos == 3'd6) begin
            for (int c = 0; c < NUM_CH; c++)
                disp_mem[c][byte_idx[BA_W-1:0]] <= {sample_q[c], sh[c][5:0]};
        end else if (state_q == FLUSH && byte_idx != BI_W'(BYTES_PER_CH)) begin
            for (int c = 0; c < NUM_CH; c++)
                disp_mem[c][byte_idx[BA_W-1:0]] <= sh[c];
        end
    end

endmodule
